// File: rtl/adc_pkg.sv
// Shared definitions for the ADC capture scheduler: state encoding and
// default configuration constants.
package adc_pkg;

  localparam int ADC_RES    = 8;
  localparam int DEF_PERIOD = 100;
  localparam int DEF_COUNT  = 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ       = 3'd1,
    ST_ACK       = 3'd2,
    ST_WAIT_TICK = 3'd3,
    ST_DRAIN     = 3'd4
  } sched_state_t;

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through sample buffer. A write while full is dropped unless
// a read pops the head on the same edge, in which case both take effect.
module sample_fifo
  import adc_pkg::*;
#(
  parameter int DATA_W  = ADC_RES,
  parameter int FIFO_AW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_rd,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_empty,
  output logic              o_full,
  output logic [FIFO_AW:0]  o_level
);
  localparam int DEPTH = 2 ** FIFO_AW;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [FIFO_AW:0]  r_wr_ptr;
  logic [FIFO_AW:0]  r_rd_ptr;
  logic [FIFO_AW:0]  w_level;
  logic              w_empty;
  logic              w_full;
  logic              w_do_rd;
  logic              w_do_wr;

  // Extra pointer bit distinguishes full from empty; level never exceeds DEPTH.
  assign w_level = r_wr_ptr - r_rd_ptr;
  assign w_empty = (w_level == '0);
  assign w_full  = w_level[FIFO_AW];
  assign w_do_rd = i_rd && !w_empty;
  assign w_do_wr = i_wr && (!w_full || w_do_rd);

  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr[FIFO_AW-1:0]] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign o_rdata = r_mem[r_rd_ptr[FIFO_AW-1:0]];
  assign o_empty = w_empty;
  assign o_full  = w_full;
  assign o_level = w_level;

endmodule

// File: rtl/adc_capture_sched.sv
// ADC sample scheduler: paces conversion requests on the driver's active-low
// start/complete handshake and buffers captured samples in a FWFT FIFO.
module adc_capture_sched
  import adc_pkg::*;
#(
  parameter int DATA_W  = ADC_RES,
  parameter int CNT_W   = 16,
  parameter int DIV_W   = 16,
  parameter int FIFO_AW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DIV_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_count,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic              adc_start_n,
  input  logic              adc_done_n,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              fifo_rd,
  output logic [DATA_W-1:0] fifo_data,
  output logic              fifo_empty,
  output logic [FIFO_AW:0]  fifo_level
);
  sched_state_t     r_state;
  sched_state_t     w_state_nxt;
  logic [DIV_W-1:0] r_period;
  logic [DIV_W-1:0] r_timer;
  logic [CNT_W-1:0] r_remaining;
  logic             r_busy;
  logic             r_done;
  logic             r_overrun;
  logic             r_start_n;
  logic             w_start_n_nxt;
  logic             w_accept;
  logic             w_finish;
  logic             w_fifo_wr;
  logic             w_fifo_full;
  logic             w_run;
  logic             w_tick;

  assign w_run  = (r_state == ST_REQ) || (r_state == ST_ACK) || (r_state == ST_WAIT_TICK);
  assign w_tick = w_run && (r_timer == '0);

  // A zero-count run parks in IDLE with busy set for one cycle, then finishes.
  always_comb begin
    w_state_nxt   = r_state;
    w_start_n_nxt = 1'b1;
    w_accept      = 1'b0;
    w_finish      = 1'b0;
    w_fifo_wr     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_busy) begin
          w_finish = 1'b1;
        end else if (start && !abort) begin
          w_accept = 1'b1;
          if (cfg_count != '0) w_state_nxt = ST_REQ;
          else                 w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        w_fifo_wr = !adc_done_n;
        if (abort)            w_state_nxt = ST_DRAIN;
        else if (!adc_done_n) w_state_nxt = ST_ACK;
        else                  w_start_n_nxt = 1'b0;
      end
      ST_ACK: begin
        if (abort) begin
          w_state_nxt = ST_DRAIN;
        end else if (adc_done_n) begin
          if (r_remaining == '0) begin
            w_state_nxt = ST_IDLE;
            w_finish    = 1'b1;
          end else begin
            w_state_nxt = ST_WAIT_TICK;
          end
        end else begin
          w_state_nxt = ST_ACK;
        end
      end
      ST_WAIT_TICK: begin
        if (abort)       w_state_nxt = ST_IDLE;
        else if (w_tick) w_state_nxt = ST_REQ;
        else             w_state_nxt = ST_WAIT_TICK;
      end
      ST_DRAIN: begin
        if (adc_done_n) w_state_nxt = ST_IDLE;
        else            w_state_nxt = ST_DRAIN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Timer reloads period-1 on each tick; ticks seen outside WAIT_TICK are lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_period    <= DIV_W'(1);
      r_timer     <= '0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
      r_start_n   <= 1'b1;
    end else begin
      r_start_n <= w_start_n_nxt;
      r_busy    <= w_accept || (w_state_nxt != ST_IDLE);
      r_done    <= w_finish;
      if (w_accept) begin
        r_period    <= (cfg_period == '0) ? DIV_W'(1) : cfg_period;
        r_timer     <= (cfg_period == '0) ? '0 : (cfg_period - DIV_W'(1));
        r_remaining <= cfg_count;
        r_overrun   <= 1'b0;
      end else begin
        if (w_tick)     r_timer <= r_period - DIV_W'(1);
        else if (w_run) r_timer <= r_timer - DIV_W'(1);
        if (w_fifo_wr) r_remaining <= r_remaining - CNT_W'(1);
        if ((w_tick && (r_state != ST_WAIT_TICK)) || (w_fifo_wr && w_fifo_full && !fifo_rd))
          r_overrun <= 1'b1;
      end
    end
  end

  sample_fifo #(
    .DATA_W  (DATA_W),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_wr    (w_fifo_wr),
    .i_wdata (adc_data),
    .i_rd    (fifo_rd),
    .o_rdata (fifo_data),
    .o_empty (fifo_empty),
    .o_full  (w_fifo_full),
    .o_level (fifo_level)
  );

  assign busy        = r_busy;
  assign done        = r_done;
  assign overrun     = r_overrun;
  assign adc_start_n = r_start_n;

endmodule

// File: tb/tb_adc_capture_sched.sv
// Bench for adc_capture_sched: table-driven and randomized capture runs against
// an arithmetic timing model and a queue model of the FIFO, plus corner sequences.
module tb_adc_capture_sched;
  localparam int DATA_W  = 8;
  localparam int CNT_W   = 16;
  localparam int DIV_W   = 16;
  localparam int FIFO_AW = 4;
  localparam int DEPTH   = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DIV_W-1:0]  cfg_period = '0;
  logic [CNT_W-1:0]  cfg_count = '0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              busy, done, overrun, adc_start_n;
  logic              adc_done_n;
  logic [DATA_W-1:0] adc_data;
  logic              fifo_rd = 1'b0;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_empty;
  logic [FIFO_AW:0]  fifo_level;

  // ADC driver model: asserts done_n lat cycles after start_n goes low, holds until released.
  logic        drv_en = 1'b1;
  logic        man_done_n = 1'b1;
  logic        drv_done_n = 1'b1;
  logic [7:0]  drv_data = 8'h00;
  int          drv_cnt = 0;
  int          drv_lat = 4;
  int          drv_idx = 0;
  logic [7:0]  drv_vals [1024];

  assign adc_done_n = drv_en ? drv_done_n : man_done_n;
  assign adc_data   = drv_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int req_t[$];
  int done_t[$];
  logic prev_start_n = 1'b1;
  bit hs_viol = 1'b0;
  logic [7:0] fifo_m[$];

  adc_capture_sched #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .DIV_W(DIV_W), .FIFO_AW(FIFO_AW)
  ) dut (
    .clk(clk), .reset(reset), .cfg_period(cfg_period), .cfg_count(cfg_count),
    .start(start), .abort(abort), .busy(busy), .done(done), .overrun(overrun),
    .adc_start_n(adc_start_n), .adc_done_n(adc_done_n), .adc_data(adc_data),
    .fifo_rd(fifo_rd), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!drv_en || adc_start_n) begin
      drv_done_n <= 1'b1;
      drv_cnt    <= 0;
    end else begin
      if (drv_cnt < drv_lat) drv_cnt <= drv_cnt + 1;
      if (drv_cnt + 1 == drv_lat) begin
        drv_done_n <= 1'b0;
        drv_data   <= drv_vals[drv_idx & 1023];
        drv_idx    <= drv_idx + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (prev_start_n && !adc_start_n) begin
      req_t.push_back(cyc);
      if (!adc_done_n) hs_viol <= 1'b1;
    end
    if (done) done_t.push_back(cyc);
    prev_start_n <= adc_start_n;
  end

  typedef struct {
    int         period;
    int         count;
    int         lat;
    logic [7:0] base;
    int         exp_int;
    bit         exp_ov;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain_check(input string tag);
    while (fifo_m.size() > 0) begin
      chk({tag, "_not_empty"}, {31'd0, fifo_empty}, 32'd0);
      chk({tag, "_data"}, {24'd0, fifo_data}, {24'd0, fifo_m[0]});
      fifo_rd = 1'b1;
      step();
      fifo_rd = 1'b0;
      void'(fifo_m.pop_front());
    end
    chk({tag, "_empty_after"}, {31'd0, fifo_empty}, 32'd1);
    chk({tag, "_level_after"}, {27'd0, fifo_level}, 32'd0);
  endtask

  task automatic wait_done(input string tag, input int db, input int bound);
    for (int k = 0; k < bound && done_t.size() == db; k++) step();
    chk({tag, "_done_seen"}, done_t.size() - db, 32'd1);
  endtask

  task automatic do_run(input string tag, input int period, input int count, input int lat,
                        input logic [7:0] base, input bit drain, input int exp_int, input bit exp_ov);
    int rb, db, n0, t_last, got;
    logic [7:0] vals[$];
    drv_en  = 1'b1;
    drv_lat = lat;
    for (int i = 0; i < count; i++) begin
      logic [7:0] v;
      v = (base != 8'h00) ? 8'(base * (i + 1)) : 8'($urandom);
      drv_vals[(drv_idx + i) & 1023] = v;
      vals.push_back(v);
    end
    rb = req_t.size();
    db = done_t.size();
    cfg_period = DIV_W'(period);
    cfg_count  = CNT_W'(count);
    start = 1'b1;
    n0 = cyc + 1;
    step();
    start = 1'b0;
    chk({tag, "_busy_after_start"}, {31'd0, busy}, 32'd1);
    chk({tag, "_overrun_cleared"}, {31'd0, overrun}, 32'd0);
    wait_done(tag, db, count * (exp_int + lat + 8) + 20);
    step(2);
    got = req_t.size() - rb;
    chk({tag, "_req_count"}, got, count);
    for (int i = 0; i < count && i < got; i++)
      chk({tag, "_req_time"}, req_t[rb + i] - n0, 1 + i * exp_int);
    if (done_t.size() > db) begin
      t_last = n0 + 1 + (count - 1) * exp_int;
      if (count > 0) chk({tag, "_done_time"}, done_t[db] - n0, t_last + lat + 3 - n0);
      else           chk({tag, "_done_time"}, done_t[db] - n0, 1);
    end
    chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    chk({tag, "_overrun"}, {31'd0, overrun}, {31'd0, exp_ov});
    chk({tag, "_handshake"}, {31'd0, hs_viol}, 32'd0);
    foreach (vals[i]) if (fifo_m.size() < DEPTH) fifo_m.push_back(vals[i]);
    chk({tag, "_level"}, {27'd0, fifo_level}, fifo_m.size());
    if (drain) drain_check(tag);
  endtask

  initial begin
    int p, c, l, pe, n0, db, lvl;

    tbl[0] = '{40, 3, 12, 8'h11, 40, 1'b0};
    tbl[1] = '{5, 4, 12, 8'h21, 20, 1'b1};
    tbl[2] = '{0, 0, 5, 8'h00, 0, 1'b0};
    tbl[3] = '{0, 2, 3, 8'h07, 8, 1'b1};
    tbl[4] = '{7, 2, 2, 8'h13, 7, 1'b0};
    tbl[5] = '{6, 2, 2, 8'h31, 12, 1'b1};
    tbl[6] = '{20, 20, 3, 8'h00, 20, 1'b1};

    #2 reset = 1'b0;
    step(2);
    chk("rst_start_n", {31'd0, adc_start_n}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_empty", {31'd0, fifo_empty}, 32'd1);
    chk("rst_level", {27'd0, fifo_level}, 32'd0);
    #3 reset = 1'b1;
    step(2);

    for (int i = 0; i < 7; i++)
      do_run($sformatf("tbl%0d", i), tbl[i].period, tbl[i].count, tbl[i].lat,
             tbl[i].base, 1'b1, tbl[i].exp_int, tbl[i].exp_ov);

    for (int r = 0; r < 12; r++) begin
      p  = $urandom_range(40, 0);
      c  = $urandom_range(20, 0);
      l  = $urandom_range(14, 1);
      pe = (p == 0) ? 1 : p;
      do_run($sformatf("rnd%0d", r), p, c, l, 8'h00, 1'b1, pe * ((l + 4) / pe + 1),
             (c > 0 && pe <= l + 4) || (c > DEPTH));
    end

    // Fill exactly to depth, then write and read on the same edge while full.
    do_run("fill16", 20, 16, 3, 8'h00, 1'b0, 20, 1'b0);
    drv_vals[drv_idx & 1023] = 8'hA5;
    drv_lat = 3;
    db = done_t.size();
    cfg_period = 16'd50;
    cfg_count  = 16'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    step(4);
    chk("fullrw_head", {24'd0, fifo_data}, {24'd0, fifo_m[0]});
    fifo_rd = 1'b1;
    step();
    fifo_rd = 1'b0;
    void'(fifo_m.pop_front());
    fifo_m.push_back(8'hA5);
    chk("fullrw_level", {27'd0, fifo_level}, 32'd16);
    wait_done("fullrw", db, 200);
    step(2);
    chk("fullrw_overrun", {31'd0, overrun}, 32'd0);
    drain_check("fullrw");

    // Abort while the request is outstanding; driver completes late during drain.
    drv_en = 1'b0;
    man_done_n = 1'b1;
    db = done_t.size();
    lvl = fifo_m.size();
    cfg_period = 16'd30;
    cfg_count  = 16'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("abrq_start_low", {31'd0, adc_start_n}, 32'd0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abrq_start_released", {31'd0, adc_start_n}, 32'd1);
    chk("abrq_busy_drain", {31'd0, busy}, 32'd1);
    man_done_n = 1'b0;
    step(3);
    chk("abrq_busy_held", {31'd0, busy}, 32'd1);
    man_done_n = 1'b1;
    step();
    chk("abrq_busy_released", {31'd0, busy}, 32'd0);
    step(2);
    chk("abrq_no_done", done_t.size() - db, 32'd0);
    chk("abrq_no_write", {27'd0, fifo_level}, lvl);

    // Abort while waiting for the next tick returns straight to idle.
    drv_en  = 1'b1;
    drv_lat = 2;
    drv_vals[drv_idx & 1023] = 8'h5A;
    db = done_t.size();
    cfg_period = 16'd30;
    cfg_count  = 16'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    step(8);
    chk("abwt_busy", {31'd0, busy}, 32'd1);
    chk("abwt_level", {27'd0, fifo_level}, 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abwt_idle", {31'd0, busy}, 32'd0);
    step(2);
    chk("abwt_no_done", done_t.size() - db, 32'd0);

    // Abort and start together: abort wins, nothing starts.
    n0 = req_t.size();
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("abst_busy", {31'd0, busy}, 32'd0);
    step(3);
    chk("abst_no_req", req_t.size() - n0, 32'd0);

    // Asynchronous reset in REQ with a non-empty FIFO.
    drv_en = 1'b0;
    cfg_count = 16'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("rstreq_start_low", {31'd0, adc_start_n}, 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("rstreq_start_n", {31'd0, adc_start_n}, 32'd1);
    chk("rstreq_busy", {31'd0, busy}, 32'd0);
    chk("rstreq_empty", {31'd0, fifo_empty}, 32'd1);
    chk("rstreq_level", {27'd0, fifo_level}, 32'd0);
    fifo_m.delete();
    #3 reset = 1'b1;
    step(2);
    chk("rstreq_idle_busy", {31'd0, busy}, 32'd0);
    do_run("post_reset", 10, 2, 3, 8'h44, 1'b1, 10, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
